// File: rtl/d_latch_pkg.sv
// rtl/d_latch_pkg.sv - shared types and defaults for the d_latch bank
package d_latch_pkg;

    localparam int DEFAULT_WIDTH = 1;

    typedef logic [DEFAULT_WIDTH-1:0] latch_word_t;

    // All-zero reset word; bits beyond the requested width stay zero as well.
    function automatic latch_word_t reset_word(input int width);
        reset_word = '0;
        for (int i = 0; i < DEFAULT_WIDTH; i++) begin
            if (i < width) begin
                reset_word[i] = 1'b0;
            end
        end
    endfunction

endpackage

// File: rtl/d_latch_cell.sv
// rtl/d_latch_cell.sv - 1-bit transparent latch, reset over gate over hold
module d_latch_cell
    import d_latch_pkg::*;
#(
    parameter logic RESET_BIT = 1'b0
) (
    output logic q,
    input  logic d,
    input  logic en,
    input  logic r
);

    logic q_q;

    always_latch begin
        if (r) begin
            q_q <= RESET_BIT;
        end else if (en) begin
            q_q <= d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/d_latch.sv
// rtl/d_latch.sv - WIDTH-bit latch bank with async high reset; D_LATCH_QN_EN adds QN = ~Q
module d_latch
    import d_latch_pkg::*;
#(
    parameter int               WIDTH       = DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VALUE = WIDTH'(reset_word(WIDTH))
) (
    output logic [WIDTH-1:0] Q,
    input  logic [WIDTH-1:0] D,
    input  logic             EN,
`ifdef D_LATCH_QN_EN
    input  logic             R,
    output logic [WIDTH-1:0] QN
`else
    input  logic             R
`endif
);

    // One cell per bit so each Q bit depends only on its own D bit.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        d_latch_cell #(
            .RESET_BIT(RESET_VALUE[i])
        ) u_cell (
            .q (Q[i]),
            .d (D[i]),
            .en(EN),
            .r (R)
        );
    end

`ifdef D_LATCH_QN_EN
    assign QN = ~Q;
`endif

endmodule

// File: tb/tb_d_latch.sv
// tb/tb_d_latch.sv - table-driven scoreboard bench for d_latch (1, 4 and 8 bit instances)
`timescale 1ns/1ps
module tb_d_latch;

    logic clk = 1'b0;
    always #10 clk = ~clk;

    logic       r1, en1, d1, q1;
    logic       r4, en4;
    logic [3:0] d4, q4;
    logic       r8, en8;
    logic [7:0] d8, q8;
`ifdef D_LATCH_QN_EN
    logic       qn1;
    logic [3:0] qn4;
    logic [7:0] qn8;
`endif

    d_latch dut1 (
        .Q (q1),
        .D (d1),
        .EN(en1),
`ifdef D_LATCH_QN_EN
        .R (r1),
        .QN(qn1)
`else
        .R (r1)
`endif
    );

    d_latch #(.WIDTH(4), .RESET_VALUE(4'h1)) dut4 (
        .Q (q4),
        .D (d4),
        .EN(en4),
`ifdef D_LATCH_QN_EN
        .R (r4),
        .QN(qn4)
`else
        .R (r4)
`endif
    );

    d_latch #(.WIDTH(8), .RESET_VALUE(8'h3C)) dut8 (
        .Q (q8),
        .D (d8),
        .EN(en8),
`ifdef D_LATCH_QN_EN
        .R (r8),
        .QN(qn8)
`else
        .R (r8)
`endif
    );

    typedef struct {
        int         sel;
        logic       r;
        logic       en;
        logic [7:0] d;
        logic [7:0] exp;
    } vec_t;

    vec_t       vecs[$];
    logic [7:0] exp_q[$];
    int         total = 0;
    int         bad   = 0;

    function automatic logic [7:0] get_q(input int sel);
        case (sel)
            1:       return {7'd0, q1};
            4:       return {4'd0, q4};
            default: return q8;
        endcase
    endfunction

    function automatic logic [7:0] width_mask(input int sel);
        case (sel)
            1:       return 8'h01;
            4:       return 8'h0F;
            default: return 8'hFF;
        endcase
    endfunction

`ifdef D_LATCH_QN_EN
    function automatic logic [7:0] get_qn(input int sel);
        case (sel)
            1:       return {7'd0, qn1};
            4:       return {4'd0, qn4};
            default: return qn8;
        endcase
    endfunction
`endif

    task automatic drive(input int sel, input logic r, input logic en, input logic [7:0] d,
                         input logic [7:0] exp);
        case (sel)
            1: begin r1 = r; en1 = en; d1 = d[0];   end
            4: begin r4 = r; en4 = en; d4 = d[3:0]; end
            default: begin r8 = r; en8 = en; d8 = d; end
        endcase
        exp_q.push_back(exp);
    endtask

    task automatic check(input string name, input int sel);
        logic [7:0] exp;
        logic [7:0] act;
        exp = exp_q.pop_front();
        act = get_q(sel);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: Q got %h want %h", name, act, exp);
        end
`ifdef D_LATCH_QN_EN
        total++;
        if (get_qn(sel) !== (~exp & width_mask(sel))) begin
            bad++;
            $display("FAIL %s_qn: QN got %h want %h", name, get_qn(sel), ~exp & width_mask(sel));
        end
`endif
    endtask

    initial begin
        r1 = 1'b1; en1 = 1'b1; d1 = 1'b0;
        r4 = 1'b1; en4 = 1'b0; d4 = 4'h0;
        r8 = 1'b1; en8 = 1'b0; d8 = 8'h00;

        // reset dominates an open gate
        vecs.push_back('{1, 1'b1, 1'b1, 8'h00, 8'h00});
        vecs.push_back('{1, 1'b1, 1'b1, 8'h01, 8'h00});
        vecs.push_back('{1, 1'b1, 1'b1, 8'h00, 8'h00});
        // release with gate closed holds reset value
        vecs.push_back('{1, 1'b1, 1'b0, 8'h00, 8'h00});
        vecs.push_back('{1, 1'b0, 1'b0, 8'h00, 8'h00});
        vecs.push_back('{1, 1'b0, 1'b0, 8'h01, 8'h00});
        vecs.push_back('{1, 1'b0, 1'b0, 8'h00, 8'h00});
        // latch high
        vecs.push_back('{1, 1'b0, 1'b0, 8'h01, 8'h00});
        vecs.push_back('{1, 1'b0, 1'b1, 8'h01, 8'h01});
        vecs.push_back('{1, 1'b0, 1'b0, 8'h01, 8'h01});
        vecs.push_back('{1, 1'b0, 1'b0, 8'h00, 8'h01});
        // latch low
        vecs.push_back('{1, 1'b0, 1'b0, 8'h00, 8'h01});
        vecs.push_back('{1, 1'b0, 1'b1, 8'h00, 8'h00});
        vecs.push_back('{1, 1'b0, 1'b0, 8'h00, 8'h00});
        vecs.push_back('{1, 1'b0, 1'b0, 8'h01, 8'h00});
        // transparency follows every change, reset mid-window, release with gate open
        vecs.push_back('{1, 1'b0, 1'b1, 8'h01, 8'h01});
        vecs.push_back('{1, 1'b0, 1'b1, 8'h00, 8'h00});
        vecs.push_back('{1, 1'b0, 1'b1, 8'h01, 8'h01});
        vecs.push_back('{1, 1'b1, 1'b1, 8'h01, 8'h00});
        vecs.push_back('{1, 1'b0, 1'b1, 8'h01, 8'h01});
        // 8-bit bank with RESET_VALUE 3C
        vecs.push_back('{8, 1'b1, 1'b0, 8'h00, 8'h3C});
        vecs.push_back('{8, 1'b0, 1'b1, 8'hA5, 8'hA5});
        vecs.push_back('{8, 1'b0, 1'b0, 8'hFF, 8'hA5});
        vecs.push_back('{8, 1'b1, 1'b0, 8'hFF, 8'h3C});
        vecs.push_back('{8, 1'b0, 1'b0, 8'hFF, 8'h3C});
        vecs.push_back('{8, 1'b0, 1'b1, 8'h0F, 8'h0F});
        vecs.push_back('{8, 1'b0, 1'b1, 8'h12, 8'h12});
        // 4-bit bank with asymmetric reset word
        vecs.push_back('{4, 1'b1, 1'b1, 8'h0F, 8'h01});
        vecs.push_back('{4, 1'b0, 1'b0, 8'h0F, 8'h01});
        vecs.push_back('{4, 1'b0, 1'b1, 8'h06, 8'h06});
        vecs.push_back('{4, 1'b0, 1'b0, 8'h09, 8'h06});

        for (int i = 0; i < vecs.size(); i++) begin
            @(posedge clk);
            drive(vecs[i].sel, vecs[i].r, vecs[i].en, vecs[i].d, vecs[i].exp);
            #10;
            check($sformatf("vec%0d", i), vecs[i].sel);
        end

        // gate falls in the same timestep as a D change: old D is held
        @(posedge clk);
        drive(8, 1'b0, 1'b1, 8'h5A, 8'h5A);
        #10 check("open_5a", 8);
        @(posedge clk);
        en8 = 1'b0;
        d8  = 8'hC3;
        exp_q.push_back(8'h5A);
        #10 check("fall_with_d", 8);

        // reset asserted over an open gate, then released while still open
        @(posedge clk);
        drive(8, 1'b1, 1'b1, 8'h77, 8'h3C);
        #10 check("rst_open", 8);
        @(posedge clk);
        r8 = 1'b0;
        exp_q.push_back(8'h77);
        #10 check("rel_open", 8);
        @(posedge clk);
        drive(8, 1'b0, 1'b0, 8'h00, 8'h77);
        #10 check("hold_after_rel", 8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
